// File: rtl/altair_mem_arb_pkg.sv
// altair_pkg: shared types and constants for the Altair main-RAM arbiter.
//   state_t        - access sequencer states (IDLE -> GRANT -> DATA)
//   OWN_CPU/OWN_DMA - encoding of the owner output
//   sat_inc        - saturating increment for the starvation counter
package altair_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W            = 4;

  // Count up by one, never past lim.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    if (v >= lim) begin
      sat_inc = lim;
    end else begin
      sat_inc = v + 4'd1;
    end
  endfunction

endpackage

// File: rtl/altair_mem_arb_if.sv
// altair_mem_arb_if: bus bundle between the two requesters, the arbiter and
// the RAM. slave = arbiter view, master = requester/RAM (environment) view.
//   cpu_*/dma_* : req, we, addr, wdata in; ack, rdata out
//   mem_*       : registered addr/wdata/rd/we out, rdata in
//   busy, owner : sequencer status
interface altair_mem_arb_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_ack;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rd;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_we, busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_we, busy, owner
  );
endinterface

// File: rtl/altair_mem_arb_arb2_pick.sv
// arb2_pick: combinational winner select between CPU and DMA.
//   cpu_req, dma_req : pending requests
//   owner            : last granted requester
//   owner_valid      : 0 until the first grant after reset (CPU wins that tie)
//   starve_hit       : starvation counter has reached its limit
//   grant_any        : some requester wins this cycle
//   grant_dma        : 1 = DMA wins, 0 = CPU wins
module arb2_pick
  import altair_pkg::*;
#(
  parameter int CPU_PRIORITY = 1
) (
  input  logic cpu_req,
  input  logic dma_req,
  input  logic owner,
  input  logic owner_valid,
  input  logic starve_hit,
  output logic grant_any,
  output logic grant_dma
);

  localparam logic PRIO_MODE = (CPU_PRIORITY != 0) ? 1'b1 : 1'b0;

  logic rr_pick_s;

  // Winner selection; only a tie needs the mode-specific rule.
  always_comb begin
    grant_any = cpu_req | dma_req;
    rr_pick_s = owner_valid & (owner == OWN_CPU);
    if (cpu_req && dma_req) begin
      grant_dma = PRIO_MODE ? starve_hit : rr_pick_s;
    end else begin
      grant_dma = dma_req;
    end
  end

endmodule

// File: rtl/altair_mem_arb.sv
// altair_mem_arb: serialises CPU and DMA accesses onto the single-port main
// RAM through an IDLE -> GRANT -> DATA sequencer.
//   clk, reset (async, active-low)
//   bus : altair_mem_arb_if.slave (requester handshakes, RAM port, status)
// Read data reaches the requester in the ack cycle by forwarding mem_rdata,
// and is held afterwards in a per-requester register.
module altair_mem_arb
  import altair_pkg::*;
#(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 8,
  parameter int CPU_PRIORITY = 1,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  altair_mem_arb_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  we_r;
  logic                  mem_rd_r;
  logic                  mem_we_r;
  logic                  busy_r;
  logic                  owner_r;
  logic                  owner_valid_r;
  logic                  cpu_ack_r;
  logic                  dma_ack_r;
  logic [DATA_WIDTH-1:0] cpu_rdata_r;
  logic [DATA_WIDTH-1:0] dma_rdata_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;

  logic                  grant_any_s;
  logic                  grant_dma_s;
  logic                  starve_hit_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  assign starve_hit_s = bus.dma_req & (cnt_r == LIMIT);

  arb2_pick #(.CPU_PRIORITY(CPU_PRIORITY)) u_pick (
    .cpu_req     (bus.cpu_req),
    .dma_req     (bus.dma_req),
    .owner       (owner_r),
    .owner_valid (owner_valid_r),
    .starve_hit  (starve_hit_s),
    .grant_any   (grant_any_s),
    .grant_dma   (grant_dma_s)
  );

  // Mux the winning requester's command fields.
  always_comb begin
    if (grant_dma_s) begin
      sel_we_s    = bus.dma_we;
      sel_addr_s  = bus.dma_addr;
      sel_wdata_s = bus.dma_wdata;
    end else begin
      sel_we_s    = bus.cpu_we;
      sel_addr_s  = bus.cpu_addr;
      sel_wdata_s = bus.cpu_wdata;
    end
  end

  // Starvation counter next value; it only moves on IDLE-cycle decisions.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (CPU_PRIORITY == 0) begin
      cnt_nxt_s = '0;
    end else if (state_r == IDLE) begin
      if (!bus.dma_req || (grant_any_s && grant_dma_s)) begin
        cnt_nxt_s = '0;
      end else if (grant_any_s) begin
        cnt_nxt_s = sat_inc(cnt_r, LIMIT);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Access sequencer with registered RAM strobes, acks and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      mem_addr_r    <= '0;
      mem_wdata_r   <= '0;
      we_r          <= 1'b0;
      mem_rd_r      <= 1'b0;
      mem_we_r      <= 1'b0;
      busy_r        <= 1'b0;
      owner_r       <= OWN_CPU;
      owner_valid_r <= 1'b0;
      cpu_ack_r     <= 1'b0;
      dma_ack_r     <= 1'b0;
      cpu_rdata_r   <= '0;
      dma_rdata_r   <= '0;
    end else begin
      mem_rd_r  <= 1'b0;
      mem_we_r  <= 1'b0;
      cpu_ack_r <= 1'b0;
      dma_ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            mem_addr_r    <= sel_addr_s;
            mem_wdata_r   <= sel_wdata_s;
            we_r          <= sel_we_s;
            mem_rd_r      <= ~sel_we_s;
            mem_we_r      <= sel_we_s;
            owner_r       <= grant_dma_s;
            owner_valid_r <= 1'b1;
            busy_r        <= 1'b1;
            state_r       <= GRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          cpu_ack_r <= (owner_r == OWN_CPU);
          dma_ack_r <= (owner_r == OWN_DMA);
          state_r   <= DATA;
        end
        DATA: begin
          // Keep the forwarded read word once the ack cycle ends.
          if (!we_r) begin
            if (owner_r == OWN_DMA) begin
              dma_rdata_r <= bus.mem_rdata;
            end else begin
              cpu_rdata_r <= bus.mem_rdata;
            end
          end
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_rd    = mem_rd_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.busy      = busy_r;
  assign bus.owner     = owner_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dma_ack   = dma_ack_r;
  // The RAM word arrives in the ack cycle itself, so forward it while ack is up.
  assign bus.cpu_rdata = (cpu_ack_r && !we_r) ? bus.mem_rdata : cpu_rdata_r;
  assign bus.dma_rdata = (dma_ack_r && !we_r) ? bus.mem_rdata : dma_rdata_r;

endmodule

// File: tb/tb_altair_mem_arb.sv
// tb_altair_mem_arb: scoreboard bench for altair_mem_arb.
// u0 runs fixed CPU priority (STARVE_LIMIT=4) against a RAM model,
// u1 runs round-robin mode. Expected acks are queued by the stimulus and
// popped by per-DUT monitors at the falling edge.
module tb_altair_mem_arb;

  typedef struct {
    bit       is_dma;
    bit       is_read;
    bit [7:0] rdata;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  exp_t q0[$];
  exp_t q1[$];
  int   rd_cnt0;
  int   cack0;
  bit   gap_en0;
  bit   have_last0;
  int   last0;
  logic [7:0] ram0 [0:8191];

  altair_mem_arb_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) bus0 ();
  altair_mem_arb_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) bus1 ();

  altair_mem_arb #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .CPU_PRIORITY(1), .STARVE_LIMIT(4)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  altair_mem_arb #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .CPU_PRIORITY(0), .STARVE_LIMIT(4)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM for u0, preloaded while reset is held.
  always @(posedge clk) begin
    if (!reset) begin
      ram0[13'h1FFF] <= 8'h3C;
      ram0[13'h0010] <= 8'h5A;
    end else begin
      if (bus0.mem_we) ram0[bus0.mem_addr] <= bus0.mem_wdata;
      if (bus0.mem_rd) bus0.mem_rdata <= ram0[bus0.mem_addr];
    end
  end

  assign bus1.mem_rdata = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=ack expected=no_ack", nm);
  endtask

  // Monitor for u0: every ack must match the head of q0.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.mem_rd) rd_cnt0++;
    if (bus0.cpu_ack) cack0++;
    if (bus0.cpu_ack && bus0.dma_ack) flag_fail("ack0_both");
    if (bus0.cpu_ack || bus0.dma_ack) begin
      if (q0.size() == 0) begin
        flag_fail("ack0_unexpected");
      end else begin
        e = q0.pop_front();
        check("ack0_who", {31'd0, bus0.dma_ack}, {31'd0, e.is_dma});
        if (e.is_read)
          check("ack0_rdata", {24'd0, (bus0.dma_ack ? bus0.dma_rdata : bus0.cpu_rdata)},
                {24'd0, e.rdata});
        if (gap_en0) begin
          if (have_last0) check("ack0_gap", cyc - last0, 3);
          have_last0 = 1'b1;
          last0      = cyc;
        end
      end
    end
  end

  // Monitor for u1 (round-robin, writes only).
  always @(negedge clk) begin
    exp_t e;
    if (bus1.cpu_ack && bus1.dma_ack) flag_fail("ack1_both");
    if (bus1.cpu_ack || bus1.dma_ack) begin
      if (q1.size() == 0) begin
        flag_fail("ack1_unexpected");
      end else begin
        e = q1.pop_front();
        check("ack1_who", {31'd0, bus1.dma_ack}, {31'd0, e.is_dma});
      end
    end
  end

  // One access on u0 from an idle sequencer, with latency checks.
  task automatic do_access(input bit dma, input bit we, input logic [12:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_rd);
    exp_t e;
    int   strobe_at;
    int   ack_at;
    bit   other;
    e.is_dma  = dma;
    e.is_read = !we;
    e.rdata   = exp_rd;
    q0.push_back(e);
    strobe_at = -1;
    ack_at    = -1;
    other     = 1'b0;
    if (dma) begin
      bus0.dma_we = we; bus0.dma_addr = addr; bus0.dma_wdata = wd; bus0.dma_req = 1'b1;
    end else begin
      bus0.cpu_we = we; bus0.cpu_addr = addr; bus0.cpu_wdata = wd; bus0.cpu_req = 1'b1;
    end
    for (int i = 0; i < 20 && ack_at < 0; i++) begin
      @(negedge clk);
      if ((bus0.mem_rd || bus0.mem_we) && strobe_at < 0) strobe_at = i;
      if (dma ? bus0.dma_ack : bus0.cpu_ack) ack_at = i;
      if (dma ? bus0.cpu_ack : bus0.dma_ack) other = 1'b1;
    end
    check("acc_ack_seen", {31'd0, ack_at >= 0}, 32'd1);
    check("acc_strobe_lat", strobe_at, 32'd0);
    check("acc_ack_lat", ack_at, 32'd1);
    check("acc_owner", {31'd0, bus0.owner}, {31'd0, dma});
    check("acc_other_ack", {31'd0, other}, 32'd0);
    #1;
    bus0.cpu_req = 1'b0;
    bus0.dma_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; rd_cnt0 = 0; cack0 = 0;
    gap_en0 = 1'b0; have_last0 = 1'b0; last0 = 0;
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = 13'h0; bus0.cpu_wdata = 8'h0;
    bus0.dma_req = 1'b0; bus0.dma_we = 1'b0; bus0.dma_addr = 13'h0; bus0.dma_wdata = 8'h0;
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = 13'h0; bus1.cpu_wdata = 8'h0;
    bus1.dma_req = 1'b0; bus1.dma_we = 1'b0; bus1.dma_addr = 13'h0; bus1.dma_wdata = 8'h0;
    reset = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ctrl", {26'd0, bus0.cpu_ack, bus0.dma_ack, bus0.mem_rd, bus0.mem_we,
                       bus0.busy, bus0.owner}, 32'd0);
    check("rst_mem_addr", {19'd0, bus0.mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, bus0.mem_wdata}, 32'd0);
    check("rst_rdata", {16'd0, bus0.cpu_rdata, bus0.dma_rdata}, 32'd0);
    check("rst_u1_busy", {31'd0, bus1.busy}, 32'd0);
    #1 reset = 1'b1;

    // Reset in the middle of a CPU write's GRANT cycle.
    @(negedge clk);
    #1;
    bus0.cpu_we = 1'b1; bus0.cpu_addr = 13'h0100; bus0.cpu_wdata = 8'h77; bus0.cpu_req = 1'b1;
    @(negedge clk);
    check("midrst_we_before", {31'd0, bus0.mem_we}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_async", {28'd0, bus0.mem_we, bus0.cpu_ack, bus0.dma_ack, bus0.busy}, 32'd0);
    bus0.cpu_req = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_after", {29'd0, bus0.busy, bus0.owner, bus0.mem_we}, 32'd0);
    #1;

    // CPU write then read back 0x0123.
    do_access(1'b0, 1'b1, 13'h0123, 8'hA5, 8'h00);
    #1;
    do_access(1'b0, 1'b0, 13'h0123, 8'h00, 8'hA5);

    // DMA read of the top word; CPU read data must be kept.
    #1;
    do_access(1'b1, 1'b0, 13'h1FFF, 8'h00, 8'h3C);
    check("dma_rdata_held", {24'd0, bus0.dma_rdata}, 32'h3C);
    check("cpu_rdata_kept", {24'd0, bus0.cpu_rdata}, 32'hA5);

    // CPU drops its request right after the grant of a read.
    #1;
    begin
      exp_t e;
      e.is_dma = 1'b0; e.is_read = 1'b1; e.rdata = 8'h5A;
      q0.push_back(e);
    end
    rd_cnt0 = 0; cack0 = 0;
    bus0.cpu_we = 1'b0; bus0.cpu_addr = 13'h0010; bus0.cpu_req = 1'b1;
    @(negedge clk);
    #1 bus0.cpu_req = 1'b0;
    repeat (8) @(negedge clk);
    check("drop_rd_count", rd_cnt0, 32'd1);
    check("drop_ack_count", cack0, 32'd1);
    check("drop_queue", q0.size(), 32'd0);

    // Fixed priority with starvation guard: C,C,C,C,D repeating.
    #1;
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      e.is_dma = (k % 5 == 4); e.is_read = 1'b0; e.rdata = 8'h00;
      q0.push_back(e);
    end
    have_last0 = 1'b0; gap_en0 = 1'b1;
    bus0.cpu_we = 1'b1; bus0.cpu_addr = 13'h0200; bus0.cpu_wdata = 8'h11;
    bus0.dma_we = 1'b1; bus0.dma_addr = 13'h0300; bus0.dma_wdata = 8'h22;
    bus0.cpu_req = 1'b1; bus0.dma_req = 1'b1;
    for (int i = 0; i < 80 && q0.size() != 0; i++) @(negedge clk);
    #1;
    bus0.cpu_req = 1'b0; bus0.dma_req = 1'b0;
    check("prio_seq_done", q0.size(), 32'd0);
    repeat (6) @(negedge clk);
    gap_en0 = 1'b0;

    // Round-robin: C,D,C,D,... starting with CPU after reset.
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      e.is_dma = (k % 2 == 1); e.is_read = 1'b0; e.rdata = 8'h00;
      q1.push_back(e);
    end
    bus1.cpu_we = 1'b1; bus1.cpu_addr = 13'h0040; bus1.cpu_wdata = 8'h33;
    bus1.dma_we = 1'b1; bus1.dma_addr = 13'h0050; bus1.dma_wdata = 8'h44;
    bus1.cpu_req = 1'b1; bus1.dma_req = 1'b1;
    for (int i = 0; i < 60 && q1.size() != 0; i++) @(negedge clk);
    #1;
    bus1.cpu_req = 1'b0; bus1.dma_req = 1'b0;
    check("rr_seq_done", q1.size(), 32'd0);
    repeat (6) @(negedge clk);
    check("final_q0", q0.size(), 32'd0);
    check("final_q1", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
